// File: rtl/core_pkg.sv
// Shared types and constants for the data-memory responder.
package core_pkg;

  localparam int BYTE_LANES = 4;
  localparam int WAIT_W     = 4;
  localparam int REQ_ADDR_W = 32;
  localparam int REQ_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

  typedef struct packed {
    logic                  we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
    logic [BYTE_LANES-1:0] be;
  } dmem_req_t;

endpackage

// File: rtl/sram_1rw.sv
// Single-port SRAM: synchronous read, per-byte write enable, contents never reset.
module sram_1rw #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned DATA_W      = 32
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [DATA_W/8-1:0]            be,
  input  logic [DATA_W-1:0]              wdata,
  output logic [DATA_W-1:0]              rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) rdata_d = mem_q[idx];
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (en && we) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Far end of the core load/store interface: one request at a time, fixed wait states, SRAM access.
//   state | meaning
//   IDLE  | ready for a request; latches it on handshake
//   WAIT  | counting wait states; SRAM access issued on the final one
//   RESP  | response held on rsp_* until rsp_ready
module dmem_responder
  import core_pkg::*;
#(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DEPTH_WORDS = 1024,
  parameter int unsigned       WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned      IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  dmem_state_e       state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  dmem_req_t         req_q, req_d;
  dmem_req_t         in_req, acc_req;
  logic              access, acc_err, cur_err;
  logic [DATA_W-1:0] sram_rdata;

  function automatic logic req_err(input dmem_req_t r);
    logic [ADDR_W-1:0] word_off;
    word_off = (r.addr - BASE_ADDR) >> 2;
    return (r.addr[1:0] != 2'b00) || (r.addr < BASE_ADDR) ||
           (word_off >= ADDR_W'(DEPTH_WORDS)) || (r.be == '0);
  endfunction

  assign in_req = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};

  // With zero wait states the access happens in the accept cycle, before req_q is loaded.
  assign acc_req = (state_q == IDLE) ? in_req : req_q;
  assign acc_err = req_err(acc_req);
  assign cur_err = req_err(req_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d = in_req;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            access  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  sram_1rw #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .DATA_W     (DATA_W)
  ) u_sram (
    .clk  (clk),
    .en   (access && !acc_err),
    .we   (acc_req.we),
    .idx  (IDX_W'((acc_req.addr - BASE_ADDR) >> 2)),
    .be   (acc_req.be),
    .wdata(acc_req.wdata),
    .rdata(sram_rdata)
  );

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = (state_q == RESP) && cur_err;
  assign rsp_rdata = ((state_q == RESP) && !req_q.we && !cur_err) ? sram_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder (2 wait states, plus a zero-wait instance).
module tb_dmem_responder;

  localparam int W_CYC = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;
  logic        z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
  logic [3:0]  z_req_be;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.WAIT_CYCLES(W_CYC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we), .req_addr(z_req_addr),
    .req_wdata(z_req_wdata), .req_be(z_req_be),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_exp(input string tag, output exp_t e);
    chk({tag, "_sb"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) e = sb.pop_front();
    else e = '{32'hxxxx_xxxx, 1'bx};
  endtask

  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input logic [31:0] exp_d, input logic exp_e);
    int   n;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    rsp_ready = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_accept"}, {31'b0, req_ready}, 32'd1);
    sb.push_back('{exp_d, exp_e});
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_lat"}, 32'(n), 32'(W_CYC + 1));
    pop_exp(tag, e);
    chk({tag, "_rdata"}, rsp_rdata, e.rdata);
    chk({tag, "_err"}, {31'b0, rsp_err}, {31'b0, e.err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int   n;
    exp_t e;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b1;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0;
    z_rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err",   {31'b0, rsp_err}, 32'd0);
    rst = 1'b0;

    // Full-word store then load; partial-byte store over it.
    xact("t1_st", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    xact("t1_ld", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
    xact("t2_st", 1'b1, 32'h10, 32'h000000AA, 4'h1, 32'h0, 1'b0);
    xact("t2_ld", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEAA, 1'b0);

    // Error cases and the last legal word.
    xact("t3_mis_ld", 1'b0, 32'h12, 32'h0, 4'hF, 32'h0, 1'b1);
    xact("t3_oor_ld", 1'b0, 32'h1000, 32'h0, 4'hF, 32'h0, 1'b1);
    xact("t3_mis_st", 1'b1, 32'h12, 32'h12345678, 4'hF, 32'h0, 1'b1);
    xact("t3_be0_st", 1'b1, 32'h10, 32'h55555555, 4'h0, 32'h0, 1'b1);
    xact("t3_chk_ld", 1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b1);
    xact("t3_keep_ld", 1'b0, 32'h10, 32'h0, 4'h3, 32'hDEADBEAA, 1'b0);
    xact("t3_last_st", 1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
    xact("t3_last_ld", 1'b0, 32'hFFC, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0);

    // Back-pressure with a new request pending.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'hF; rsp_ready = 1'b0;
    chk("t4_accept", {31'b0, req_ready}, 32'd1);
    sb.push_back('{32'hDEADBEAA, 1'b0});
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("t4_lat", 32'(n), 32'(W_CYC + 1));
    pop_exp("t4", e);
    req_valid = 1'b1; req_addr = 32'hFFC;
    repeat (5) begin
      chk("t4_hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("t4_hold_rdata", rsp_rdata, e.rdata);
      chk("t4_hold_err",   {31'b0, rsp_err}, {31'b0, e.err});
      chk("t4_hold_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_new_accept", {31'b0, req_ready}, 32'd1);
    chk("t4_rsp_done",   {31'b0, rsp_valid}, 32'd0);
    sb.push_back('{32'hCAFEF00D, 1'b0});
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("t4_new_lat", 32'(n), 32'(W_CYC + 1));
    pop_exp("t4_new", e);
    chk("t4_new_rdata", rsp_rdata, e.rdata);

    // Reset while a store sits in WAIT.
    xact("t5_pre", 1'b1, 32'h20, 32'h11112222, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h33334444; req_be = 4'hF;
    chk("t5_accept", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("t5_in_wait", {31'b0, req_ready}, 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("t5_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("t5_rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("t5_rst_rsp_err",   {31'b0, rsp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    xact("t5_ld", 1'b0, 32'h20, 32'h0, 4'hF, 32'h11112222, 1'b0);

    // Zero wait states: store then back-to-back loads with req_valid held high.
    @(negedge clk);
    z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 32'h0; z_req_wdata = 32'h5A5A5A5A;
    z_req_be = 4'hF; z_rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t6_req_ready", {31'b0, z_req_ready}, 32'((i % 2) == 0));
      chk("t6_rsp_valid", {31'b0, z_rsp_valid}, 32'((i % 2) == 1));
      if (z_req_ready === 1'b1) begin
        if (i == 0) sb.push_back('{32'h0, 1'b0});
        else        sb.push_back('{32'h5A5A5A5A, 1'b0});
      end
      if (z_rsp_valid === 1'b1) begin
        pop_exp("t6", e);
        chk("t6_rdata", z_rsp_rdata, e.rdata);
        chk("t6_err",   {31'b0, z_rsp_err}, {31'b0, e.err});
      end
      @(negedge clk);
      if (i == 0) z_req_we = 1'b0;
    end
    z_req_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
